rggen_bit_field_irq_gen: RTL and testbench
==========================================

# rggen_bit_field_irq_gen

Interrupt request generator that consumes the status vector produced by the set/clear-on-write status bit fields (w0c/w1c). It masks the status bits with a per-bit enable and coalesces new events by count threshold and timeout. It drives a single registered interrupt request that holds until software clears every enabled pending bit. It sits between a register block's status fields and the system interrupt controller.

## Interface

- WIDTH, 1, number of status/enable bits
- COUNT_WIDTH, 4, width of the event counter and threshold
- TIMEOUT_WIDTH, 8, width of the coalescing timer and timeout value

Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).

- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- i_status  input  WIDTH  status vector, driven by the o_value outputs of the status bit fields
- i_enable  input  WIDTH  per-bit interrupt enable (1 = enabled)
- i_threshold  input  COUNT_WIDTH  number of new events that forces assertion; 0 or 1 = no count coalescing
- i_timeout  input  TIMEOUT_WIDTH  cycles allowed in coalescing before forced assertion; 0 = no time coalescing
- o_irq  output  1  interrupt request, registered, active-high
- o_pending_count  output  COUNT_WIDTH  saturating count of new events since leaving IDLE

## Operation

- pending = i_status & i_enable. any_pending = |pending.
- pending_d is a registered copy of pending. rising = pending & ~pending_d, per bit. new_events = popcount(rising), saturated to COUNT_WIDTH.
- Disabling a bit removes it from pending. Re-enabling a set bit counts as a new event.
- State machine states:
  - IDLE: o_irq=0, count=0, timer=0.
  - COALESCE: o_irq=0, timer runs.
  - ASSERT: o_irq=1.
- IDLE → ASSERT when any_pending and (i_threshold<=1 or i_timeout==0 or new_events>=i_threshold).
- IDLE → COALESCE when any_pending and none of the above hold.
- On leaving IDLE: count=new_events, timer=1.
- COALESCE → ASSERT when count+new_events (saturated) >= i_threshold, or timer==i_timeout.
- Otherwise in COALESCE: timer+1 (saturating), count accumulates.
- ASSERT: count keeps accumulating (saturating). Stays in ASSERT while any_pending.
- COALESCE or ASSERT → IDLE when any_pending==0. This has priority over every other transition at the same edge.
- Counter and timer saturate at all-ones and never wrap.
- Threshold and timeout are sampled every cycle. A change mid-COALESCE takes effect at the next edge.

## Timing

- Reset values: state=IDLE, o_irq=0, o_pending_count=0, pending_d=0, timer=0. Reset is asynchronous and may occur mid-coalesce; outputs go to 0 immediately.
- All decisions use i_status/i_enable as sampled at the edge. o_irq and o_pending_count are flop outputs; there is no combinational path from any input to o_irq.
- Immediate mode (i_threshold<=1 or i_timeout==0): pending rises before edge k → o_irq=1 after edge k (one-cycle latency).
- Timeout: COALESCE entered at edge k with count below threshold and no further events → o_irq=1 after edge k+i_timeout-1.
- Threshold: the edge at which the accumulated count reaches i_threshold moves the state to ASSERT. o_irq rises after that edge.
- Deassertion: the last enabled pending bit is cleared before edge m → o_irq=0 and o_pending_count=0 after edge m.
- Simultaneous clear of one bit and set of another leaves any_pending=1: state holds, and the new bit counts as an event.

## Test plan

- Reset, then i_status=0 → o_irq=0 and o_pending_count=0 for 20 cycles. Assert rst_n=0 while in ASSERT → o_irq=0 immediately.
- WIDTH=4, enable=4'hF, threshold=1, set bit 2 → o_irq=1 one edge later. Clear bit 2 → o_irq=0 one edge later.
- Threshold=3, timeout=200, three single-bit events on separate cycles 5 cycles apart → o_irq=1 after the edge sampling the third event; o_pending_count=3.
- Threshold=8, timeout=10, one event at edge k → o_irq=1 after edge k+9. Clear on the timeout edge instead → state returns to IDLE, o_irq stays 0.
- Enable=4'h1, set bit 3 → no irq. Enable bit 3 while status is still set → counted as an event; irq follows the threshold/timeout rules.
- Threshold=15, COUNT_WIDTH=4, 20 events with no clear → o_pending_count saturates at 15 and does not wrap.

Source files
------------

// File: rtl/rggen_bit_field_irq_gen.sv
// rggen_bit_field_irq_gen
//
// Interrupt request generator for a register block's w0c/w1c status fields.
// Status bits are masked by a per-bit enable, and new events (enabled bits that
// rise) are coalesced by an event-count threshold and a timeout before the
// interrupt is raised. Once raised, the request holds until software has
// cleared every enabled pending bit.
//
// Ports:
//   clk              clock
//   rst_n            asynchronous active-low reset
//   i_status         status vector from the status bit fields
//   i_enable         per-bit interrupt enable (1 = enabled)
//   i_threshold      event count that forces assertion (0 or 1 = no count coalescing)
//   i_timeout        coalescing cycles before forced assertion (0 = no time coalescing)
//   o_irq            registered, active-high interrupt request
//   o_pending_count  saturating count of new events since leaving IDLE
module rggen_bit_field_irq_gen #(
    parameter int WIDTH         = 1,
    parameter int COUNT_WIDTH   = 4,
    parameter int TIMEOUT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         i_status,
    input  logic [WIDTH-1:0]         i_enable,
    input  logic [COUNT_WIDTH-1:0]   i_threshold,
    input  logic [TIMEOUT_WIDTH-1:0] i_timeout,
    output logic                     o_irq,
    output logic [COUNT_WIDTH-1:0]   o_pending_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COALESCE = 2'd1,
        ASSERT   = 2'd2
    } state_t;

    localparam logic [COUNT_WIDTH-1:0]   COUNT_MAX = '1;
    localparam logic [TIMEOUT_WIDTH-1:0] TIMER_MAX = '1;

    state_t                   state;
    state_t                   state_next;
    logic [WIDTH-1:0]         pending;
    logic [WIDTH-1:0]         pending_d;
    logic [WIDTH-1:0]         rising;
    logic                     any_pending;
    logic [31:0]              ones;
    logic [COUNT_WIDTH-1:0]   new_events;
    logic [COUNT_WIDTH:0]     count_sum;
    logic [COUNT_WIDTH-1:0]   count_acc;
    logic [TIMEOUT_WIDTH:0]   timer_sum;
    logic [TIMEOUT_WIDTH-1:0] timer_inc;
    logic                     immediate;
    logic [COUNT_WIDTH-1:0]   count;
    logic [COUNT_WIDTH-1:0]   count_next;
    logic [TIMEOUT_WIDTH-1:0] timer;
    logic [TIMEOUT_WIDTH-1:0] timer_next;
    logic                     irq;
    logic                     irq_next;

    assign pending     = i_status & i_enable;
    assign any_pending = |pending;
    // A bit that is re-enabled while its status is still set shows up here as
    // a rising edge, so it is counted as a fresh event.
    assign rising      = pending & ~pending_d;

    // Number of bits that rose this cycle, clipped to the counter range.
    always_comb begin
        ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + 32'(rising[i]);
        end
        if (ones > 32'(COUNT_MAX)) begin
            new_events = COUNT_MAX;
        end else begin
            new_events = ones[COUNT_WIDTH-1:0];
        end
    end

    // Saturating accumulate of the event counter and increment of the timer;
    // the extra top bit is the carry that signals saturation.
    assign count_sum = {1'b0, count} + {1'b0, new_events};
    assign count_acc = count_sum[COUNT_WIDTH] ? COUNT_MAX : count_sum[COUNT_WIDTH-1:0];
    assign timer_sum = {1'b0, timer} + {{TIMEOUT_WIDTH{1'b0}}, 1'b1};
    assign timer_inc = timer_sum[TIMEOUT_WIDTH] ? TIMER_MAX : timer_sum[TIMEOUT_WIDTH-1:0];

    assign immediate = (i_threshold <= COUNT_WIDTH'(1)) || (i_timeout == '0);

    // State and datapath registers; reset clears everything at once, so an
    // asserted request drops immediately even mid-coalesce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pending_d <= '0;
            count     <= '0;
            timer     <= '0;
            irq       <= 1'b0;
        end else begin
            state     <= state_next;
            pending_d <= pending;
            count     <= count_next;
            timer     <= timer_next;
            irq       <= irq_next;
        end
    end

    // Next-state decision. Losing every pending bit wins over any other move.
    // The timeout compares the timer value being loaded at this edge, so a
    // COALESCE entered at edge k times out at edge k+i_timeout-1; using >=
    // lets a timeout lowered mid-coalesce still fire at the next edge.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (any_pending) begin
                    if (immediate || (new_events >= i_threshold)) begin
                        state_next = ASSERT;
                    end else begin
                        state_next = COALESCE;
                    end
                end
            end
            COALESCE: begin
                if (!any_pending) begin
                    state_next = IDLE;
                end else if ((count_acc >= i_threshold) || (timer_inc >= i_timeout)) begin
                    state_next = ASSERT;
                end
            end
            ASSERT: begin
                if (!any_pending) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Register inputs for the outputs and datapath. The request is taken from
    // the next state so that o_irq itself is a flop, not a state decode.
    always_comb begin
        irq_next   = (state_next == ASSERT);
        count_next = count;
        timer_next = timer;
        if (state_next == IDLE) begin
            count_next = '0;
            timer_next = '0;
        end else if (state == IDLE) begin
            count_next = new_events;
            timer_next = TIMEOUT_WIDTH'(1);
        end else begin
            count_next = count_acc;
            if (state == COALESCE) begin
                timer_next = timer_inc;
            end
        end
    end

    assign o_irq           = irq;
    assign o_pending_count = count;

endmodule

// File: tb/tb_rggen_bit_field_irq_gen.sv
// tb_rggen_bit_field_irq_gen
//
// Directed bench for rggen_bit_field_irq_gen with four status bits. Inputs are
// driven 1 ns after a rising edge and outputs are sampled at the same point,
// so each check sees the result of the edge just taken.
module tb_rggen_bit_field_irq_gen;

    logic       clk;
    logic       rst_n;
    logic [3:0] status;
    logic [3:0] enable;
    logic [3:0] threshold;
    logic [7:0] timeout;
    logic       irq;
    logic [3:0] pending_count;

    int checks;
    int passed;
    int expected_count;

    rggen_bit_field_irq_gen #(
        .WIDTH         (4),
        .COUNT_WIDTH   (4),
        .TIMEOUT_WIDTH (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_status        (status),
        .i_enable        (enable),
        .i_threshold     (threshold),
        .i_timeout       (timeout),
        .o_irq           (irq),
        .o_pending_count (pending_count)
    );

    // 100 MHz clock, rising edges at 5, 15, 25 ns ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive all data inputs at once.
    task automatic applyStimulus(input logic [3:0] s, input logic [3:0] e,
                                 input logic [3:0] th, input logic [7:0] to);
        status    = s;
        enable    = e;
        threshold = th;
        timeout   = to;
    endtask

    // Advance past the next rising edge to a stable sampling point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare both outputs against the hand-computed values.
    task automatic checkOutput(input string tag, input logic exp_irq, input logic [3:0] exp_count);
        checks++;
        assert (irq === exp_irq) passed++;
        else $error("[TB] FAIL %s irq: observed %b expected %b", tag, irq, exp_irq);
        checks++;
        assert (pending_count === exp_count) passed++;
        else $error("[TB] FAIL %s count: observed %0d expected %0d", tag, pending_count, exp_count);
    endtask

    initial begin
        checks = 0;
        passed = 0;
        rst_n  = 1'b0;
        applyStimulus(4'h0, 4'hF, 4'd1, 8'd200);
        #12;
        checkOutput("reset", 1'b0, 4'd0);
        #10;
        rst_n = 1'b1;

        // Quiet inputs: nothing happens for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            tick();
            checkOutput("idle", 1'b0, 4'd0);
        end

        // Immediate mode: one-edge latency in, one-edge latency out.
        applyStimulus(4'b0100, 4'hF, 4'd1, 8'd200);
        #1;
        checkOutput("imm_before_edge", 1'b0, 4'd0);
        tick();
        checkOutput("imm_assert", 1'b1, 4'd1);
        applyStimulus(4'b0000, 4'hF, 4'd1, 8'd200);
        tick();
        checkOutput("imm_clear", 1'b0, 4'd0);

        // Threshold 3: three events five cycles apart.
        applyStimulus(4'b0001, 4'hF, 4'd3, 8'd200);
        tick();
        checkOutput("thr_ev1", 1'b0, 4'd1);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("thr_wait1", 1'b0, 4'd1);
        applyStimulus(4'b0011, 4'hF, 4'd3, 8'd200);
        tick();
        checkOutput("thr_ev2", 1'b0, 4'd2);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("thr_wait2", 1'b0, 4'd2);
        applyStimulus(4'b0111, 4'hF, 4'd3, 8'd200);
        tick();
        checkOutput("thr_ev3", 1'b1, 4'd3);
        applyStimulus(4'b0000, 4'hF, 4'd3, 8'd200);
        tick();
        checkOutput("thr_clear", 1'b0, 4'd0);

        // Clearing one bit while setting another keeps coalescing and counts.
        applyStimulus(4'b0001, 4'hF, 4'd3, 8'd200);
        tick();
        checkOutput("swap_ev1", 1'b0, 4'd1);
        applyStimulus(4'b0010, 4'hF, 4'd3, 8'd200);
        tick();
        checkOutput("swap_ev2", 1'b0, 4'd2);
        applyStimulus(4'b0100, 4'hF, 4'd3, 8'd200);
        tick();
        checkOutput("swap_ev3", 1'b1, 4'd3);
        applyStimulus(4'b0000, 4'hF, 4'd3, 8'd200);
        tick();
        checkOutput("swap_clear", 1'b0, 4'd0);

        // Asynchronous reset while asserted.
        applyStimulus(4'b0001, 4'hF, 4'd1, 8'd200);
        tick();
        checkOutput("rst_pre", 1'b1, 4'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async", 1'b0, 4'd0);
        applyStimulus(4'b0000, 4'hF, 4'd1, 8'd200);
        #3;
        rst_n = 1'b1;
        tick();
        checkOutput("rst_after", 1'b0, 4'd0);

        // Timeout 10: one event at edge k asserts after edge k+9.
        applyStimulus(4'b0001, 4'hF, 4'd8, 8'd10);
        tick();
        checkOutput("to_enter", 1'b0, 4'd1);
        for (int j = 1; j <= 8; j++) begin
            tick();
            checkOutput("to_wait", 1'b0, 4'd1);
        end
        tick();
        checkOutput("to_fire", 1'b1, 4'd1);
        applyStimulus(4'b0000, 4'hF, 4'd8, 8'd10);
        tick();
        checkOutput("to_clear", 1'b0, 4'd0);

        // Same, but the clear lands on the timeout edge.
        applyStimulus(4'b0001, 4'hF, 4'd8, 8'd10);
        tick();
        checkOutput("to2_enter", 1'b0, 4'd1);
        for (int j = 1; j <= 8; j++) tick();
        checkOutput("to2_k8", 1'b0, 4'd1);
        applyStimulus(4'b0000, 4'hF, 4'd8, 8'd10);
        tick();
        checkOutput("to2_clear_edge", 1'b0, 4'd0);
        tick();
        checkOutput("to2_stay_idle", 1'b0, 4'd0);

        // Lowering the threshold mid-coalesce takes effect at the next edge.
        applyStimulus(4'b0001, 4'hF, 4'd8, 8'd200);
        tick();
        checkOutput("chg_enter", 1'b0, 4'd1);
        applyStimulus(4'b0001, 4'hF, 4'd1, 8'd200);
        tick();
        checkOutput("chg_fire", 1'b1, 4'd1);
        applyStimulus(4'b0000, 4'hF, 4'd1, 8'd200);
        tick();
        checkOutput("chg_clear", 1'b0, 4'd0);

        // Masked bit stays silent; enabling it while set is a new event.
        applyStimulus(4'b1000, 4'h1, 4'd1, 8'd200);
        tick();
        tick();
        checkOutput("mask_silent", 1'b0, 4'd0);
        applyStimulus(4'b1000, 4'h9, 4'd1, 8'd200);
        tick();
        checkOutput("mask_enable", 1'b1, 4'd1);
        applyStimulus(4'b1000, 4'h1, 4'd1, 8'd200);
        tick();
        checkOutput("mask_disable", 1'b0, 4'd0);
        applyStimulus(4'b0000, 4'hF, 4'd1, 8'd200);
        tick();
        checkOutput("mask_restore", 1'b0, 4'd0);

        // Twenty events without a clear: counter saturates at 15.
        applyStimulus(4'b0001, 4'hF, 4'd15, 8'd200);
        tick();
        checkOutput("sat_ev1", 1'b0, 4'd1);
        for (int i = 0; i < 19; i++) begin
            expected_count = (i + 2 > 15) ? 15 : i + 2;
            applyStimulus(4'b0011, 4'hF, 4'd15, 8'd200);
            tick();
            checkOutput("sat_rise", expected_count == 15, 4'(expected_count));
            applyStimulus(4'b0001, 4'hF, 4'd15, 8'd200);
            tick();
            checkOutput("sat_fall", expected_count == 15, 4'(expected_count));
        end
        applyStimulus(4'b0000, 4'hF, 4'd15, 8'd200);
        tick();
        checkOutput("sat_clear", 1'b0, 4'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
